// File: rtl/puf_challenge_reader.sv
// Host-side reader for a serialized ring-oscillator PUF.
// Accepts a challenge, runs NUM_EVAL PUF evaluations, and returns a per-bit
// majority vote, an instability mask and a timeout flag.
module puf_challenge_reader #(
    parameter int NUM_EVAL = 5,
    parameter int TIMEOUT  = 1023,
    parameter int TO_W     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_challenge,
    output logic       puf_en,
    output logic       puf_rst,
    output logic [7:0] puf_chall,
    input  logic [7:0] puf_response,
    input  logic       puf_ready,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [7:0] rsp_unstable,
    output logic       rsp_timeout
);

    typedef enum logic [1:0] {IDLE, PREP, WAIT, DONE} state_t;

    localparam logic [3:0]      NUM_EVAL_C = 4'(NUM_EVAL);
    localparam logic [3:0]      HALF_C     = 4'(NUM_EVAL / 2);
    localparam logic [TO_W-1:0] TIMEOUT_C  = TO_W'(TIMEOUT);

    state_t            state, state_d;
    logic [3:0]        eval_cnt, eval_cnt_d;
    logic [7:0][3:0]   ones, ones_d, ones_sum;
    logic [TO_W-1:0]   to_cnt, to_cnt_d;
    logic              ready_q;
    logic              capture;

    logic              req_ready_d, puf_en_d, puf_rst_d, rsp_valid_d, rsp_timeout_d;
    logic [7:0]        puf_chall_d, rsp_data_d, rsp_unstable_d;

    // A response only counts on a fresh rising edge of puf_ready.
    assign capture = puf_ready & ~ready_q;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Registered outputs, counters and the puf_ready edge detector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready    <= 1'b1;
            puf_en       <= 1'b0;
            puf_rst      <= 1'b1;
            puf_chall    <= 8'h00;
            rsp_valid    <= 1'b0;
            rsp_data     <= 8'h00;
            rsp_unstable <= 8'h00;
            rsp_timeout  <= 1'b0;
            eval_cnt     <= '0;
            ones         <= '0;
            to_cnt       <= '0;
            ready_q      <= 1'b0;
        end else begin
            req_ready    <= req_ready_d;
            puf_en       <= puf_en_d;
            puf_rst      <= puf_rst_d;
            puf_chall    <= puf_chall_d;
            rsp_valid    <= rsp_valid_d;
            rsp_data     <= rsp_data_d;
            rsp_unstable <= rsp_unstable_d;
            rsp_timeout  <= rsp_timeout_d;
            eval_cnt     <= eval_cnt_d;
            ones         <= ones_d;
            to_cnt       <= to_cnt_d;
            ready_q      <= puf_ready;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        // NOTE: every signal gets a hold-value default first so no path
        // through the case statement can infer a latch.
        state_d        = state;
        req_ready_d    = req_ready;
        puf_en_d       = puf_en;
        puf_rst_d      = puf_rst;
        puf_chall_d    = puf_chall;
        rsp_valid_d    = rsp_valid;
        rsp_data_d     = rsp_data;
        rsp_unstable_d = rsp_unstable;
        rsp_timeout_d  = rsp_timeout;
        eval_cnt_d     = eval_cnt;
        ones_d         = ones;
        to_cnt_d       = to_cnt;

        for (int i = 0; i < 8; i++) begin
            ones_sum[i] = ones[i] + {3'b000, puf_response[i]};
        end

        case (state)
            IDLE: begin
                req_ready_d = 1'b1;
                puf_rst_d   = 1'b1;
                puf_en_d    = 1'b0;
                if (req_valid && req_ready) begin
                    puf_chall_d = req_challenge;
                    eval_cnt_d  = '0;
                    ones_d      = '0;
                    req_ready_d = 1'b0;
                    state_d     = PREP;
                end
            end
            PREP: begin
                // Outputs for the first WAIT cycle are set up here.
                to_cnt_d  = '0;
                puf_rst_d = 1'b0;
                puf_en_d  = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                if (capture) begin
                    ones_d     = ones_sum;
                    eval_cnt_d = eval_cnt + 4'd1;
                    puf_en_d   = 1'b0;
                    puf_rst_d  = 1'b1;
                    if (eval_cnt + 4'd1 == NUM_EVAL_C) begin
                        state_d       = DONE;
                        rsp_valid_d   = 1'b1;
                        rsp_timeout_d = 1'b0;
                        for (int i = 0; i < 8; i++) begin
                            rsp_data_d[i]     = ones_sum[i] > HALF_C;
                            rsp_unstable_d[i] = (ones_sum[i] != 4'd0) && (ones_sum[i] != NUM_EVAL_C);
                        end
                    end else begin
                        state_d = PREP;
                    end
                end else if (to_cnt + 1'b1 == TIMEOUT_C) begin
                    state_d        = DONE;
                    rsp_valid_d    = 1'b1;
                    rsp_timeout_d  = 1'b1;
                    rsp_data_d     = 8'h00;
                    rsp_unstable_d = 8'hFF;
                    puf_en_d       = 1'b0;
                    puf_rst_d      = 1'b1;
                end else begin
                    to_cnt_d = to_cnt + 1'b1;
                end
            end
            DONE: begin
                if (rsp_valid && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_puf_challenge_reader.sv
// Randomized self-checking bench for puf_challenge_reader with a behavioural
// PUF model and a majority-vote reference model.
module tb_puf_challenge_reader;

    localparam int NE = 3;
    localparam int TO = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_challenge;
    logic       puf_en;
    logic       puf_rst;
    logic [7:0] puf_chall;
    logic [7:0] puf_response;
    logic       puf_ready;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [7:0] rsp_unstable;
    logic       rsp_timeout;

    int n_checks = 0;
    int n_pass   = 0;

    // PUF model controls: queued responses, never-ready and stuck-high modes.
    logic [7:0] resp_q[$];
    bit         puf_silent = 1'b0;
    bit         puf_stuck  = 1'b0;

    puf_challenge_reader #(.NUM_EVAL(NE), .TIMEOUT(TO), .TO_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_challenge(req_challenge),
        .puf_en       (puf_en),
        .puf_rst      (puf_rst),
        .puf_chall    (puf_chall),
        .puf_response (puf_response),
        .puf_ready    (puf_ready),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_unstable (rsp_unstable),
        .rsp_timeout  (rsp_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Behavioural PUF: after a random delay with en high and rst low, raises
    // ready with the next queued response; afterwards the response bus is junk.
    initial begin
        int cnt;
        int dly;
        cnt = 0;
        dly = 3;
        puf_ready    = 1'b0;
        puf_response = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (puf_stuck) begin
                puf_ready = 1'b1;
            end else if (puf_rst || !puf_en) begin
                puf_ready = 1'b0;
                cnt = 0;
                dly = int'($urandom_range(1, 6));
            end else if (puf_silent) begin
                puf_ready = 1'b0;
            end else if (!puf_ready) begin
                cnt++;
                if (cnt >= dly) begin
                    puf_ready    = 1'b1;
                    puf_response = (resp_q.size() > 0) ? resp_q.pop_front() : 8'($urandom);
                end
            end else begin
                puf_response = 8'($urandom);
            end
        end
    end

    // One full request: issue, monitor, check against the reference model,
    // optionally stall the response for hold cycles, then complete the handshake.
    task automatic run_request(input string tag, input logic [7:0] chall, input int n_resp,
                               input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2,
                               input bit exp_to, input int hold);
        logic [7:0] rs[3];
        logic [7:0] exp_data, exp_unst;
        int guard, waits, entries, chall_bad, ones;
        logic prev_rst;

        rs[0] = r0; rs[1] = r1; rs[2] = r2;
        for (int e = 0; e < n_resp; e++) resp_q.push_back(rs[e]);

        // Reference model: count ones per bit, majority and disagreement.
        if (exp_to) begin
            exp_data = 8'h00;
            exp_unst = 8'hFF;
        end else begin
            for (int i = 0; i < 8; i++) begin
                ones = 0;
                for (int e = 0; e < NE; e++) ones += int'(rs[e][i]);
                exp_data[i] = (ones * 2 > NE);
                exp_unst[i] = (ones != 0) && (ones != NE);
            end
        end

        guard = 0;
        while (!req_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        check({tag, "_req_ready"}, req_ready, 1);

        req_challenge = chall;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_challenge = 8'($urandom);
        check({tag, "_prep"}, {req_ready, puf_rst, puf_en}, 3'b010);
        @(posedge clk); #1;
        check({tag, "_wait_entry"}, {puf_rst, puf_en}, 2'b01);

        waits = 1; entries = 1; chall_bad = 0; prev_rst = puf_rst;
        guard = 0;
        while (!rsp_valid && guard < 500) begin
            @(posedge clk); #1; guard++;
            if (puf_chall !== chall) chall_bad++;
            if (prev_rst && !puf_rst) entries++;
            if (puf_en) waits++;
            prev_rst = puf_rst;
        end
        check({tag, "_rsp_valid"}, rsp_valid, 1);
        check({tag, "_chall_held"}, chall_bad, 0);
        check({tag, "_evals"}, entries, exp_to ? 1 : NE);
        if (exp_to) check({tag, "_to_cycles"}, waits, TO);
        check({tag, "_data"}, rsp_data, exp_data);
        check({tag, "_unstable"}, rsp_unstable, exp_unst);
        check({tag, "_timeout"}, rsp_timeout, exp_to);
        check({tag, "_done_puf"}, {puf_rst, puf_en}, 2'b10);

        for (int k = 0; k < hold; k++) begin
            req_valid = 1'($urandom);
            req_challenge = 8'($urandom);
            @(posedge clk); #1;
            check({tag, "_hold"}, {rsp_valid, rsp_data, rsp_unstable, rsp_timeout, req_ready, puf_chall},
                  {1'b1, exp_data, exp_unst, exp_to, 1'b0, chall});
        end
        req_valid = 1'b0;

        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, "_after_hs"}, {rsp_valid, req_ready, rsp_data, rsp_unstable, rsp_timeout},
              {1'b0, 1'b1, exp_data, exp_unst, exp_to});
        @(posedge clk); #1;
        check({tag, "_idle"}, {puf_rst, puf_en, req_ready, puf_chall}, {1'b1, 1'b0, 1'b1, chall});
    endtask

    // Global watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] base;
        int guard, entries;
        logic prev_rst;

        rst = 1'b1;
        req_valid = 1'b0;
        req_challenge = 8'h00;
        rsp_ready = 1'b0;
        #23;
        rst = 1'b0;

        // Reset state held for 20 idle cycles.
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            check("reset_idle", {req_ready, puf_rst, puf_en, rsp_valid, rsp_timeout, puf_chall, rsp_data, rsp_unstable},
                  {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00});
        end

        // Directed requests.
        run_request("stable",  8'h3C, 3, 8'hA5, 8'hA5, 8'hA5, 1'b0, 0);
        run_request("vote",    8'h11, 3, 8'hF0, 8'hF1, 8'h70, 1'b0, 10);

        puf_silent = 1'b1;
        run_request("silent",  8'h77, 0, 8'h00, 8'h00, 8'h00, 1'b1, 3);
        puf_silent = 1'b0;

        // Ready already high before WAIT never counts as a capture.
        puf_stuck = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        run_request("stuck",   8'h99, 0, 8'h00, 8'h00, 8'h00, 1'b1, 0);
        puf_stuck = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Randomized requests with mostly-stable, occasionally flipping bits.
        for (int n = 0; n < 12; n++) begin
            base = 8'($urandom);
            run_request("rand", 8'($urandom),
                        3, base ^ 8'($urandom & $urandom & $urandom),
                        base ^ 8'($urandom & $urandom & $urandom),
                        base ^ 8'($urandom & $urandom & $urandom),
                        1'b0, int'($urandom_range(0, 3)));
        end

        // Asynchronous reset in the second evaluation's WAIT.
        resp_q.push_back(8'hFF);
        resp_q.push_back(8'hFF);
        resp_q.push_back(8'hFF);
        req_challenge = 8'hC3;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        entries = 0; prev_rst = puf_rst; guard = 0;
        while (entries < 2 && guard < 200) begin
            @(posedge clk); #1; guard++;
            if (prev_rst && !puf_rst) entries++;
            prev_rst = puf_rst;
        end
        check("abort_reach_wait2", entries, 2);
        #3;
        rst = 1'b1;
        #1;
        check("abort_async", {req_ready, puf_rst, puf_en, rsp_valid, rsp_timeout, puf_chall, rsp_data, rsp_unstable},
              {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00});
        resp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_no_rsp", rsp_valid, 0);
        run_request("post_abort", 8'h5A, 3, 8'h0F, 8'h03, 8'h01, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
